// File: rtl/paquetizador_n_w.sv
`default_nettype none
// ============================================================================
// Module      : paquetizador_n_w
// Description : Packs LANES narrow beats into one wide word, with gap
//               tolerance, backpressure and partial-word flush.
// Revision    : 1.0 - initial release
// ============================================================================
module paquetizador_n_w #(
  parameter int IN_W      = 8,
  parameter int LANES     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk_4f,
  input  logic                         reset,
  input  logic [IN_W-1:0]              data_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic                         flush_in,
  output logic [IN_W*LANES-1:0]        data_out,
  output logic                         valid_out,
  output logic [$clog2(LANES+1)-1:0]   count_out,
  input  logic                         ready_out
);

  localparam int c_out_w = IN_W * LANES;
  localparam int c_cw    = $clog2(LANES + 1);
  localparam int c_idx_w = $clog2(LANES);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(LANES - 1);

  logic [c_idx_w-1:0] r_idx;
  logic [c_out_w-1:0] r_acc;
  logic [c_out_w-1:0] r_data;
  logic [c_cw-1:0]    r_count;
  logic               r_valid;

  logic               w_slot_free;
  logic               w_last;
  logic               w_accept;
  logic               w_complete;
  logic               w_emit;
  logic [c_cw-1:0]    w_n;
  logic [c_out_w-1:0] w_merged;

  // The last lane can only be taken when the output register can accept the word.
  assign w_slot_free = !r_valid || ready_out;
  assign w_last      = (r_idx == c_last_idx);
  assign ready_in    = !w_last || w_slot_free;
  assign w_accept    = valid_in && ready_in;
  assign w_complete  = w_accept && w_last;
  assign w_n         = c_cw'(r_idx) + c_cw'(w_accept);
  assign w_emit      = w_complete || (flush_in && w_slot_free && (w_n != '0));

  always_comb begin
    w_merged = r_acc;
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_idx == c_idx_w'(i)) begin
          if (MSB_FIRST != 0) begin
            w_merged[c_out_w-1-i*IN_W -: IN_W] = data_in;
          end else begin
            w_merged[i*IN_W +: IN_W] = data_in;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_emit) begin
      // w_n equals LANES on completion, so one load path covers both cases.
      r_data  <= w_merged;
      r_count <= w_n;
      r_valid <= 1'b1;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      r_valid <= r_valid && !ready_out;
      if (w_accept) begin
        r_acc <= w_merged;
        r_idx <= r_idx + c_idx_w'(1);
      end
    end
  end

  assign data_out  = r_data;
  assign count_out = r_count;
  assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_paquetizador_n_w.sv
`default_nettype none
// ============================================================================
// Module      : tb_paquetizador_n_w
// Description : Directed vector bench for the narrow-to-wide packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paquetizador_n_w;

  logic        clk_4f = 1'b0;
  logic        reset;

  logic [7:0]  data_a;
  logic        valid_a, flush_a, ready_out_a;
  logic        ready_in_a, valid_out_a;
  logic [31:0] data_out_a;
  logic [2:0]  count_out_a;

  logic [3:0]  data_b;
  logic        valid_b, flush_b, ready_out_b;
  logic        ready_in_b, valid_out_b;
  logic [31:0] data_out_b;
  logic [3:0]  count_out_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_4f = ~clk_4f;

  paquetizador_n_w #(.IN_W(8), .LANES(4), .MSB_FIRST(1)) u_dut_a (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_a),
    .valid_in  (valid_a),
    .ready_in  (ready_in_a),
    .flush_in  (flush_a),
    .data_out  (data_out_a),
    .valid_out (valid_out_a),
    .count_out (count_out_a),
    .ready_out (ready_out_a)
  );

  paquetizador_n_w #(.IN_W(4), .LANES(8), .MSB_FIRST(0)) u_dut_b (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_b),
    .valid_in  (valid_b),
    .ready_in  (ready_in_b),
    .flush_in  (flush_b),
    .data_out  (data_out_b),
    .valid_out (valid_out_b),
    .count_out (count_out_b),
    .ready_out (ready_out_b)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        ro;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_d;
    logic [2:0]  e_c;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic ro,
                              logic e_rdy, logic e_v, logic [31:0] e_d, logic [2:0] e_c);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.ro = ro;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_d = e_d; t.e_c = e_c;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; ready_in is checked before the rising
  // edge, registered outputs just after it.
  task automatic step_a(vec_t t, string tag);
    @(negedge clk_4f);
    valid_a = t.v; data_a = t.d; flush_a = t.f; ready_out_a = t.ro;
    #1;
    chk({tag, " ready_in"}, {31'd0, ready_in_a}, {31'd0, t.e_rdy});
    @(posedge clk_4f);
    #1;
    chk({tag, " valid_out"}, {31'd0, valid_out_a}, {31'd0, t.e_v});
    if (t.e_v) begin
      chk({tag, " data_out"}, data_out_a, t.e_d);
      chk({tag, " count_out"}, {29'd0, count_out_a}, {29'd0, t.e_c});
    end
  endtask

  vec_t tbl[$];

  initial begin
    // beat-driven idle row with ready_out high
    tbl.push_back(mk(1, 8'h2F, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h5E, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h8D, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hBC, 0, 1, 1, 1, 32'h2F5E8DBC, 4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    // gaps between beats
    tbl.push_back(mk(1, 8'h2F, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h5E, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h8D, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hBC, 0, 1, 1, 1, 32'h2F5E8DBC, 4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    // backpressure: second word's last beat stalls
    tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 0, 0, 1, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h05, 0, 0, 1, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h06, 0, 0, 1, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h07, 0, 0, 1, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h08, 0, 0, 0, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h08, 0, 0, 0, 1, 32'h01020304, 4));
    tbl.push_back(mk(1, 8'h08, 0, 1, 1, 1, 32'h05060708, 4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
    // partial flush, then flush with nothing pending
    tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hBB, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 32'hAABB0000, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0));
    // flush coinciding with word completion
    tbl.push_back(mk(1, 8'h10, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h20, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h30, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 1, 1, 1, 1, 32'h10203040, 4));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0));
    // flush merged with a beat, then flush blocked by a held word
    tbl.push_back(mk(1, 8'hCC, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hDD, 1, 1, 1, 1, 32'hCCDD0000, 2));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 1, 1, 32'hCCDD0000, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 32'hCCDD0000, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 32'hEE000000, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));

    reset = 1'b1;
    data_a = '0; valid_a = 0; flush_a = 0; ready_out_a = 1;
    data_b = '0; valid_b = 0; flush_b = 0; ready_out_b = 1;
    #1;
    chk("rst valid_out", {31'd0, valid_out_a}, 32'd0);
    chk("rst data_out", data_out_a, 32'd0);
    chk("rst count_out", {29'd0, count_out_a}, 32'd0);
    chk("rst ready_in", {31'd0, ready_in_a}, 32'd1);
    @(negedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step_a(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset mid-word while a completed word is still held
    for (int i = 1; i <= 7; i++) begin
      step_a(mk(1, 8'(i), 0, 0, 1, (i >= 4), 32'h01020304, 4), $sformatf("pre%0d", i));
    end
    @(negedge clk_4f);
    valid_a = 0; reset = 1'b1;
    #1;
    chk("midrst valid_out", {31'd0, valid_out_a}, 32'd0);
    chk("midrst data_out", data_out_a, 32'd0);
    chk("midrst count_out", {29'd0, count_out_a}, 32'd0);
    chk("midrst ready_in", {31'd0, ready_in_a}, 32'd1);
    @(posedge clk_4f);
    #1;
    chk("midrst hold valid_out", {31'd0, valid_out_a}, 32'd0);
    @(negedge clk_4f);
    reset = 1'b0;
    step_a(mk(1, 8'h11, 0, 1, 1, 0, 0, 0), "post0");
    step_a(mk(1, 8'h22, 0, 1, 1, 0, 0, 0), "post1");
    step_a(mk(1, 8'h33, 0, 1, 1, 0, 0, 0), "post2");
    step_a(mk(1, 8'h44, 0, 1, 1, 1, 32'h11223344, 4), "post3");
    step_a(mk(0, 8'h00, 0, 1, 1, 0, 0, 0), "post4");

    // LSB-first nibble packer
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_4f);
      valid_b = 1; data_b = 4'(i);
      #1;
      chk($sformatf("nib%0d ready_in", i), {31'd0, ready_in_b}, 32'd1);
      @(posedge clk_4f);
      #1;
      chk($sformatf("nib%0d valid_out", i), {31'd0, valid_out_b}, (i == 8) ? 32'd1 : 32'd0);
    end
    chk("nib data_out", data_out_b, 32'h87654321);
    chk("nib count_out", {28'd0, count_out_b}, 32'd8);
    @(negedge clk_4f);
    valid_b = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
